// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster timing generator with 25 MHz pixel enable derived from CLOCK_50
module vga_timing #(
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [9:0]  VGA_X,
  output logic [9:0]  VGA_Y,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        video_on,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

  // All boundaries are pre-sized to the 10-bit counter width so every
  // comparison below is a plain 10-bit compare.
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BP + H_ACT);
  localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BP + V_ACT);

  logic d;
  logic pix_en;
  logic x_wrap;
  logic y_wrap;
  logic h_vis;
  logic v_vis;

  // Pixel enable is the divider high phase, so counters move as VGA_CLK falls
  // and each pixel coordinate is held for two CLOCK_50 cycles.
  assign pix_en = d;
  assign x_wrap = (VGA_X == H_LAST);
  assign y_wrap = (VGA_Y == V_LAST);

  // Divide-by-two divider producing the DAC pixel clock
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) d <= 1'b0;
    else       d <= ~d;
  end

  // Horizontal and vertical raster counters, vertical steps on horizontal wrap
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      VGA_X <= '0;
      VGA_Y <= '0;
    end else if (pix_en) begin
      if (x_wrap) begin
        VGA_X <= '0;
        VGA_Y <= y_wrap ? 10'd0 : VGA_Y + 10'd1;
      end else begin
        VGA_X <= VGA_X + 10'd1;
      end
    end
  end

  // Frame pulse and frame counter, both on the edge that returns the raster to (0,0)
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_tick <= pix_en && x_wrap && y_wrap;
      if (pix_en && x_wrap && y_wrap) frame_count <= frame_count + 16'd1;
    end
  end

  // Zero-latency decode of syncs and the visible window from the counter registers
  always_comb begin
    h_vis       = (VGA_X >= H_VIS_START) && (VGA_X < H_VIS_END);
    v_vis       = (VGA_Y >= V_VIS_START) && (VGA_Y < V_VIS_END);
    VGA_HS      = (VGA_X >= H_SYNC_END);
    VGA_VS      = (VGA_Y >= V_SYNC_END);
    VGA_BLANK_N = h_vis && v_vis;
    video_on    = h_vis && v_vis;
    VGA_SYNC_N  = 1'b0;
    VGA_CLK     = d;
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed self-checking bench for vga_timing using a reduced raster
module tb_vga_timing;

  // Reduced raster keeps a whole frame to a few hundred cycles.
  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;   // 17
  localparam int VT = VS + VB + VA + VF;   // 9
  localparam int FRAME = 2 * HT * VT;      // 306 CLOCK_50 cycles

  logic        CLOCK_50;
  logic        reset;
  logic [9:0]  VGA_X, VGA_Y;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK;
  logic        video_on, frame_tick;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n;   // CLOCK_50 edges since the last reset release

  vga_timing #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .VGA_X      (VGA_X),
    .VGA_Y      (VGA_Y),
    .VGA_HS     (VGA_HS),
    .VGA_VS     (VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N (VGA_SYNC_N),
    .VGA_CLK    (VGA_CLK),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .frame_count(frame_count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    n++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_cmp++; if (VGA_X !== 10'd0)       begin n_bad++; $display("FAIL reset_x: got %0d expected 0", VGA_X); end
    n_cmp++; if (VGA_Y !== 10'd0)       begin n_bad++; $display("FAIL reset_y: got %0d expected 0", VGA_Y); end
    n_cmp++; if (VGA_HS !== 1'b0)       begin n_bad++; $display("FAIL reset_hs: got %b expected 0", VGA_HS); end
    n_cmp++; if (VGA_VS !== 1'b0)       begin n_bad++; $display("FAIL reset_vs: got %b expected 0", VGA_VS); end
    n_cmp++; if (VGA_BLANK_N !== 1'b0)  begin n_bad++; $display("FAIL reset_blank: got %b expected 0", VGA_BLANK_N); end
    n_cmp++; if (VGA_CLK !== 1'b0)      begin n_bad++; $display("FAIL reset_clk: got %b expected 0", VGA_CLK); end
    n_cmp++; if (frame_tick !== 1'b0)   begin n_bad++; $display("FAIL reset_tick: got %b expected 0", frame_tick); end
    n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", frame_count); end
    n_cmp++; if (VGA_SYNC_N !== 1'b0)   begin n_bad++; $display("FAIL reset_sync_n: got %b expected 0", VGA_SYNC_N); end
    step();
    step();
    n_cmp++; if (VGA_X !== 10'd0) begin n_bad++; $display("FAIL reset_hold_x: got %0d expected 0", VGA_X); end
    reset = 1'b0;
    n = 0;
  endtask

  task automatic test_first_advance();
    step();
    n_cmp++; if (VGA_X !== 10'd0)  begin n_bad++; $display("FAIL adv_edge1_x: got %0d expected 0", VGA_X); end
    n_cmp++; if (VGA_CLK !== 1'b1) begin n_bad++; $display("FAIL adv_edge1_clk: got %b expected 1", VGA_CLK); end
    step();
    n_cmp++; if (VGA_X !== 10'd1)  begin n_bad++; $display("FAIL adv_edge2_x: got %0d expected 1", VGA_X); end
    n_cmp++; if (VGA_CLK !== 1'b0) begin n_bad++; $display("FAIL adv_edge2_clk: got %b expected 0", VGA_CLK); end
  endtask

  // Walks one full frame from the release state (n == 0), checking every
  // output against the raster model each cycle, then the frame totals.
  task automatic test_frame();
    int hs_low = 0, vs_low = 0, vid = 0, ticks = 0;
    int fx = -1, fy = -1, lx = -1, ly = -1;
    int p, ex, ey;
    logic exp_vid;
    logic [9:0] px;
    logic pclk;
    reset = 1'b1;
    #1;
    step();
    reset = 1'b0;
    n = 0;
    px = VGA_X;
    pclk = VGA_CLK;
    for (int i = 0; i <= FRAME; i++) begin
      if (i > 0) begin
        px = VGA_X;
        pclk = VGA_CLK;
        step();
      end
      p = n / 2;
      ex = p % HT;
      ey = (p / HT) % VT;
      exp_vid = (ex >= HS + HB) && (ex < HS + HB + HA) && (ey >= VS + VB) && (ey < VS + VB + VA);
      n_cmp++; if (VGA_X !== 10'(ex)) begin n_bad++; $display("FAIL frame_x n=%0d: got %0d expected %0d", n, VGA_X, ex); end
      n_cmp++; if (VGA_Y !== 10'(ey)) begin n_bad++; $display("FAIL frame_y n=%0d: got %0d expected %0d", n, VGA_Y, ey); end
      n_cmp++; if (VGA_CLK !== 1'(n % 2)) begin n_bad++; $display("FAIL frame_clk n=%0d: got %b expected %0d", n, VGA_CLK, n % 2); end
      n_cmp++; if (VGA_HS !== (ex >= HS)) begin n_bad++; $display("FAIL frame_hs n=%0d: got %b expected %b", n, VGA_HS, ex >= HS); end
      n_cmp++; if (VGA_VS !== (ey >= VS)) begin n_bad++; $display("FAIL frame_vs n=%0d: got %b expected %b", n, VGA_VS, ey >= VS); end
      n_cmp++; if (VGA_BLANK_N !== exp_vid) begin n_bad++; $display("FAIL frame_blank n=%0d: got %b expected %b", n, VGA_BLANK_N, exp_vid); end
      n_cmp++; if (video_on !== exp_vid) begin n_bad++; $display("FAIL frame_video n=%0d: got %b expected %b", n, video_on, exp_vid); end
      n_cmp++; if (VGA_SYNC_N !== 1'b0) begin n_bad++; $display("FAIL frame_sync_n n=%0d: got %b expected 0", n, VGA_SYNC_N); end
      n_cmp++; if (frame_tick !== (i == FRAME)) begin n_bad++; $display("FAIL frame_tick n=%0d: got %b expected %b", n, frame_tick, i == FRAME); end
      if (i > 0 && VGA_X !== px) begin
        n_cmp++; if (!(pclk === 1'b1 && VGA_CLK === 1'b0)) begin n_bad++; $display("FAIL x_change_phase n=%0d: clk %b->%b expected 1->0", n, pclk, VGA_CLK); end
      end
      if (i == 2 * HT) begin
        n_cmp++; if (VGA_X !== 10'd0 || VGA_Y !== 10'd1) begin n_bad++; $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", VGA_X, VGA_Y); end
      end
      if (i < 2 * HT && !VGA_HS) hs_low++;
      if (i < FRAME) begin
        if (!VGA_VS) vs_low++;
        if (video_on) begin
          vid++;
          if (fx < 0) begin fx = int'(VGA_X); fy = int'(VGA_Y); end
          lx = int'(VGA_X); ly = int'(VGA_Y);
        end
      end
      if (frame_tick) ticks++;
    end
    n_cmp++; if (hs_low != 2 * HS) begin n_bad++; $display("FAIL hs_low_cycles: got %0d expected %0d", hs_low, 2 * HS); end
    n_cmp++; if (vs_low != 2 * VS * HT) begin n_bad++; $display("FAIL vs_low_cycles: got %0d expected %0d", vs_low, 2 * VS * HT); end
    n_cmp++; if (vid != 2 * HA * VA) begin n_bad++; $display("FAIL video_cycles: got %0d expected %0d", vid, 2 * HA * VA); end
    n_cmp++; if (fx != 7 || fy != 4) begin n_bad++; $display("FAIL video_first: got (%0d,%0d) expected (7,4)", fx, fy); end
    n_cmp++; if (lx != 14 || ly != 7) begin n_bad++; $display("FAIL video_last: got (%0d,%0d) expected (14,7)", lx, ly); end
    n_cmp++; if (ticks != 1) begin n_bad++; $display("FAIL tick_count: got %0d expected 1", ticks); end
    n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL frame_count_1: got %0d expected 1", frame_count); end
    step();
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL tick_width: got %b expected 0", frame_tick); end
  endtask

  task automatic test_count_wrap();
    int k = 0;
    force dut.frame_count = 16'hFFFF;
    step();
    release dut.frame_count;
    n_cmp++; if (frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_preload: got %0d expected 65535", frame_count); end
    while ((n % FRAME) != 0 && k < FRAME) begin
      step();
      k++;
    end
    n_cmp++; if ((n % FRAME) != 0) begin n_bad++; $display("FAIL wrap_timeout: got n=%0d expected frame boundary", n); end
    n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL wrap_count: got %0d expected 0", frame_count); end
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL wrap_tick: got %b expected 1", frame_tick); end
  endtask

  task automatic test_mid_reset();
    int k = 0;
    int early = 0;
    while (!(VGA_X == 10'd10 && VGA_Y == 10'd5) && k < 2 * FRAME) begin
      step();
      k++;
    end
    n_cmp++; if (VGA_X !== 10'd10 || VGA_Y !== 10'd5) begin n_bad++; $display("FAIL midrst_reach: got (%0d,%0d) expected (10,5)", VGA_X, VGA_Y); end
    #3;
    reset = 1'b1;
    #1;
    n_cmp++; if (VGA_X !== 10'd0 || VGA_Y !== 10'd0) begin n_bad++; $display("FAIL midrst_xy: got (%0d,%0d) expected (0,0)", VGA_X, VGA_Y); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL midrst_tick: got %b expected 0", frame_tick); end
    n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL midrst_count: got %0d expected 0", frame_count); end
    n_cmp++; if (VGA_CLK !== 1'b0 || VGA_HS !== 1'b0 || VGA_VS !== 1'b0) begin n_bad++; $display("FAIL midrst_decode: got clk=%b hs=%b vs=%b expected 0 0 0", VGA_CLK, VGA_HS, VGA_VS); end
    step();
    reset = 1'b0;
    n = 0;
    for (int i = 1; i < FRAME; i++) begin
      step();
      if (frame_tick) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL midrst_early_tick: got %0d expected 0", early); end
    step();
    n_cmp++; if (frame_tick !== 1'b1) begin n_bad++; $display("FAIL midrst_tick_at_frame: got %b expected 1", frame_tick); end
    n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL midrst_count_after: got %0d expected 1", frame_count); end
  endtask

  initial begin
    reset = 1'b1;
    n = 0;
    test_reset();
    test_first_advance();
    test_frame();
    test_count_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
